branch_pred_ctrl: RTL and testbench
===================================

// Module: branch_pred_ctrl
// PURPOSE
//  Sequences the branch target buffer for the pipelined ARM core. Registers each BTB
//  lookup result and tracks the prediction through decode and execute. Compares it with
//  the execute-stage resolution, then issues fetch redirects, pipeline flushes and BTB
//  update writes. Sits between fetch, the BTB and the execute stage, and also keeps
//  performance counters.
// PARAMETERS
//  RESET_PC        32'h0000_0000  fetch address driven on redirect_pc after reset
//  CNT_W           16             width of the saturating branch/mispredict counters
//  RECOVER_CYCLES  1              cycles BTB redirects are suppressed after a mispredict (>=1)
// PORTS
//  clk            in   1      clock; everything is on the rising edge
//  reset          in   1      asynchronous, active-high reset
//  stall          in   1      pipeline stall; freezes the tracker and ignores ex_* inputs
//  fetch_pc       in   32     PC presented to the BTB this cycle
//  btb_hit        in   1      BTB hit for the fetch_pc of the previous cycle (registered BTB)
//  btb_pred_pc    in   32     BTB target; valid when btb_hit=1
//  ex_is_branch   in   1      a branch is resolving in execute this cycle
//  ex_taken       in   1      resolved direction
//  ex_target      in   32     resolved target
//  redirect       out  1      load redirect_pc into the fetch PC next cycle
//  redirect_pc    out  32     redirect address
//  flush_f        out  1      kill the instruction in fetch
//  flush_d        out  1      kill the instruction in decode
//  btb_update     out  1      one-cycle BTB write strobe
//  btb_pc         out  32     BTB write tag
//  btb_bta        out  32     BTB write target
//  branch_cnt     out  CNT_W  resolved branches (saturating)
//  mispred_cnt    out  CNT_W  mispredicted branches (saturating)
// BEHAVIOUR
//  - All outputs are registered. Reset values: redirect=0, redirect_pc=RESET_PC, flush_*=0,
//    btb_update=0, btb_pc=0, btb_bta=0, counters=0, FSM=RUN, tracker entries invalid.
//  - Lookup alignment: lk_pc <= fetch_pc every non-stall cycle. btb_hit/btb_pred_pc refer to lk_pc.
//  - Tracker: two entries, D then E, each holding {valid, pred_taken, pred_tgt, pc}.
//    - On a non-stall cycle, D <= {1, btb_hit, btb_pred_pc, lk_pc} and E <= D.
//    - stall=1 holds both entries.
//  - Resolution (E.valid & ex_is_branch & !stall):
//    - mispredict = (E.pred_taken != ex_taken) | (ex_taken & E.pred_tgt != ex_target).
//    - correct PC = ex_taken ? ex_target : E.pc+4 (mod 2^32).
//    - branch_cnt increments on every resolution; mispred_cnt also increments on a
//      mispredict. Both saturate at all-ones.
//  - On a mispredict, next cycle: redirect=1, redirect_pc=correct PC, flush_f=flush_d=1.
//    D and E are invalidated in the same cycle. FSM RUN->RECOVER.
//  - BTB predicted-taken (RUN, !stall, btb_hit, no mispredict this cycle), next cycle:
//    redirect=1, redirect_pc=btb_pred_pc, flush_f=1, flush_d=0.
//  - Priority: execute mispredict > BTB redirect > none. Simultaneous events resolve
//    to the mispredict only.
//  - BTB update: when resolution has ex_taken=1 and (!E.pred_taken | target mismatch),
//    next cycle btb_update=1, btb_pc=E.pc, btb_bta=ex_target.
//    - Not-taken mispredicts never write the BTB.
//    - btb_pc/btb_bta hold their values when btb_update=0.
//  - FSM:
//    - RUN: normal operation.
//    - RECOVER: BTB hits are ignored (D is still loaded with pred_taken=0) for
//      RECOVER_CYCLES non-stall cycles, counted by rec_cnt; then RECOVER->RUN.
//    - A new mispredict in RECOVER reloads rec_cnt.
//  - All pulse outputs last exactly one cycle.
//  - Reset mid-operation clears everything immediately; no redirect is issued after
//    reset deasserts.
// STRUCTURE
//  - Shared package bp_pkg: typedef bp_entry_t {valid, pred_taken, pred_tgt[31:0], pc[31:0]};
//    enum bp_state_e {RUN, RECOVER}; localparam PC_INC = 32'd4.
//  - One sub-module: bp_sat_counter (CNT_W, inc, sat), instantiated twice.
//  - Everything else stays in this module.
// TESTING
//  1. Reset -> redirect=0, redirect_pc=0, counters 0, no pulses for 5 idle cycles.
//  2. btb_hit=1, btb_pred_pc=0x100 for lk_pc=0x40 -> next cycle redirect=1, pc=0x100,
//     flush_f=1, flush_d=0.
//  3. E predicted not-taken at pc 0x80; ex_taken=1, tgt 0x200 -> redirect 0x200,
//     flush_f/d=1, btb_update=1 (0x80->0x200), mispred_cnt=1.
//  4. E predicted taken to 0x300; resolves not-taken at pc 0x90 -> redirect 0x94,
//     btb_update=0.
//  5. Mispredict and BTB hit in the same cycle -> only the execute redirect fires.
//     A BTB hit in the following RECOVER cycle produces no redirect.
//  6. stall=1 across a resolving branch -> no pulses, tracker held.
//     Mispredict pulses appear after stall drops.
//     Force CNT_W=2: counters stick at 3.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch predictor control shared types.
// Tracker entry, FSM states and PC step.
package bp_pkg;

  typedef struct packed {
    logic        valid;
    logic        pred_taken;
    logic [31:0] pred_tgt;
    logic [31:0] pc;
  } bp_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating event counter.
// Sticks at all-ones instead of wrapping.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;
  assign cnt   = r_cnt;

  // count up until every bit is set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/branch_pred_ctrl.sv
// BTB sequencing: tracks predictions to execute,
// issues redirects, flushes and BTB writes.
module branch_pred_ctrl
  import bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          CNT_W          = 16,
  parameter int          RECOVER_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      fetch_pc,
  input  logic             btb_hit,
  input  logic [31:0]      btb_pred_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_f,
  output logic             flush_d,
  output logic             btb_update,
  output logic [31:0]      btb_pc,
  output logic [31:0]      btb_bta,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int REC_W = $clog2(RECOVER_CYCLES + 1);
  localparam logic [REC_W-1:0] REC_LOAD =
    REC_W'(RECOVER_CYCLES);
  localparam logic [REC_W-1:0] REC_ONE = REC_W'(1);

  logic [31:0]      r_lk_pc;
  bp_entry_t        r_d;
  bp_entry_t        r_e;
  bp_state_e        r_state;
  logic [REC_W-1:0] r_rec_cnt;
  logic             r_redirect;
  logic [31:0]      r_redirect_pc;
  logic             r_flush_f;
  logic             r_flush_d;
  logic             r_btb_update;
  logic [31:0]      r_btb_pc;
  logic [31:0]      r_btb_bta;

  logic             w_resolve;
  logic             w_tgt_miss;
  logic             w_mispred;
  logic [31:0]      w_fix_pc;
  logic             w_btb_wr;
  logic             w_btb_redir;
  logic             w_hit_ok;
  bp_state_e        w_state_nx;
  logic [REC_W-1:0] w_rec_nx;

  // compare the execute resolution with the E prediction
  always_comb begin
    w_resolve   = r_e.valid & ex_is_branch & ~stall;
    w_tgt_miss  = r_e.pred_tgt != ex_target;
    w_mispred   = w_resolve &
                  ((r_e.pred_taken != ex_taken) |
                   (ex_taken & w_tgt_miss));
    w_fix_pc    = ex_taken ? ex_target
                           : r_e.pc + PC_INC;
    w_btb_wr    = w_resolve & ex_taken &
                  (~r_e.pred_taken | w_tgt_miss);
    w_btb_redir = w_hit_ok & ~stall & btb_hit &
                  ~w_mispred;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_rec_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_rec_cnt <= w_rec_nx;
    end
  end

  // FSM next state: mispredicts (re)arm the recovery window
  always_comb begin
    w_state_nx = r_state;
    w_rec_nx   = r_rec_cnt;
    if (w_mispred) begin
      w_state_nx = RECOVER;
      w_rec_nx   = REC_LOAD;
    end else if (r_state == RECOVER && !stall) begin
      if (r_rec_cnt <= REC_ONE) begin
        w_state_nx = RUN;
        w_rec_nx   = '0;
      end else begin
        w_rec_nx   = r_rec_cnt - REC_ONE;
      end
    end
  end

  // FSM outputs: BTB hits only count while running
  always_comb begin
    w_hit_ok = 1'b0;
    unique case (1'b1)
      (r_state == RUN):     w_hit_ok = 1'b1;
      (r_state == RECOVER): w_hit_ok = 1'b0;
      default:              w_hit_ok = 1'b0;
    endcase
  end

  // lookup alignment and D/E prediction tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lk_pc <= '0;
      r_d     <= '0;
      r_e     <= '0;
    end else if (!stall) begin
      r_lk_pc <= fetch_pc;
      if (w_mispred) begin
        r_d <= '0;
        r_e <= '0;
      end else begin
        r_e <= r_d;
        r_d <= '{valid:      1'b1,
                 pred_taken: btb_hit & w_hit_ok,
                 pred_tgt:   btb_pred_pc,
                 pc:         r_lk_pc};
      end
    end
  end

  // registered redirect, flush and BTB write outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= RESET_PC;
      r_flush_f     <= 1'b0;
      r_flush_d     <= 1'b0;
      r_btb_update  <= 1'b0;
      r_btb_pc      <= '0;
      r_btb_bta     <= '0;
    end else begin
      r_redirect   <= w_mispred | w_btb_redir;
      r_flush_f    <= w_mispred | w_btb_redir;
      r_flush_d    <= w_mispred;
      r_btb_update <= w_btb_wr;
      if (w_mispred) begin
        r_redirect_pc <= w_fix_pc;
      end else if (w_btb_redir) begin
        r_redirect_pc <= btb_pred_pc;
      end
      if (w_btb_wr) begin
        r_btb_pc  <= r_e.pc;
        r_btb_bta <= ex_target;
      end
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign flush_f     = r_flush_f;
  assign flush_d     = r_flush_d;
  assign btb_update  = r_btb_update;
  assign btb_pc      = r_btb_pc;
  assign btb_bta     = r_btb_bta;

  bp_sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_resolve),
    .cnt   (branch_cnt)
  );

  bp_sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_mispred),
    .cnt   (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: directed cases
// plus random traffic against a behavioural model.
module tb_branch_pred_ctrl;

  localparam int RECOVER_CYCLES = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        btb_hit;
  logic [31:0] btb_pred_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;

  logic        redirect, flush_f, flush_d, btb_update;
  logic [31:0] redirect_pc, btb_pc, btb_bta;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        redirect2, flush_f2, flush_d2, btb_update2;
  logic [31:0] redirect_pc2, btb_pc2, btb_bta2;
  logic [1:0]  branch_cnt2, mispred_cnt2;

  branch_pred_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .fetch_pc(fetch_pc), .btb_hit(btb_hit),
    .btb_pred_pc(btb_pred_pc),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_f(flush_f), .flush_d(flush_d),
    .btb_update(btb_update), .btb_pc(btb_pc),
    .btb_bta(btb_bta), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  branch_pred_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall),
    .fetch_pc(fetch_pc), .btb_hit(btb_hit),
    .btb_pred_pc(btb_pred_pc),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .flush_f(flush_f2), .flush_d(flush_d2),
    .btb_update(btb_update2), .btb_pc(btb_pc2),
    .btb_bta(btb_bta2), .branch_cnt(branch_cnt2),
    .mispred_cnt(mispred_cnt2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: index 0 = decode slot, 1 = execute slot
  bit          m_v[2];
  bit          m_pt[2];
  logic [31:0] m_tgt[2];
  logic [31:0] m_pc[2];
  int          m_rec;
  bit          e_redirect, e_ff, e_fd, e_upd;
  logic [31:0] e_pc, e_bpc, e_bta;
  int          e_br, e_mp;

  function automatic logic [31:0] sat(int v, int mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  task automatic chk(string n, logic [31:0] a,
                     logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_pt[i] = 0;
      m_tgt[i] = '0; m_pc[i] = '0;
    end
    m_rec = 0;
    e_redirect = 0; e_ff = 0; e_fd = 0; e_upd = 0;
    e_pc = 32'h0; e_bpc = '0; e_bta = '0;
    e_br = 0; e_mp = 0;
  endtask

  // one rising edge of behaviour, from the rules
  task automatic model_step(logic [31:0] lk);
    bit res, mis, wr, use_hit;
    logic [31:0] fix;
    if (stall) begin
      e_redirect = 0; e_ff = 0; e_fd = 0; e_upd = 0;
      return;
    end
    res = m_v[1] && ex_is_branch;
    mis = res && ((m_pt[1] != ex_taken) ||
                  (ex_taken && m_tgt[1] != ex_target));
    fix = ex_taken ? ex_target : m_pc[1] + 32'd4;
    wr  = res && ex_taken &&
          (!m_pt[1] || m_tgt[1] != ex_target);
    use_hit = (m_rec == 0) && btb_hit;
    e_redirect = mis || use_hit;
    e_ff = e_redirect;
    e_fd = mis;
    e_upd = wr;
    if (mis) e_pc = fix;
    else if (use_hit) e_pc = btb_pred_pc;
    if (wr) begin e_bpc = m_pc[1]; e_bta = ex_target; end
    if (res) e_br++;
    if (mis) e_mp++;
    if (mis) begin
      m_v[0] = 0; m_v[1] = 0;
      m_rec = RECOVER_CYCLES;
    end else begin
      m_v[1] = m_v[0]; m_pt[1] = m_pt[0];
      m_tgt[1] = m_tgt[0]; m_pc[1] = m_pc[0];
      m_v[0] = 1; m_pt[0] = use_hit;
      m_tgt[0] = btb_pred_pc; m_pc[0] = lk;
      if (m_rec > 0) m_rec--;
    end
  endtask

  logic [31:0] m_lk;

  task automatic compare_all();
    chk("redirect", 32'(redirect), 32'(e_redirect));
    chk("redirect_pc", redirect_pc, e_pc);
    chk("flush_f", 32'(flush_f), 32'(e_ff));
    chk("flush_d", 32'(flush_d), 32'(e_fd));
    chk("btb_update", 32'(btb_update), 32'(e_upd));
    chk("btb_pc", btb_pc, e_bpc);
    chk("btb_bta", btb_bta, e_bta);
    chk("branch_cnt", 32'(branch_cnt), sat(e_br, 65535));
    chk("mispred_cnt", 32'(mispred_cnt), sat(e_mp, 65535));
    chk("redirect2", 32'(redirect2), 32'(e_redirect));
    chk("redirect_pc2", redirect_pc2, e_pc);
    chk("btb_update2", 32'(btb_update2), 32'(e_upd));
    chk("branch_cnt2", 32'(branch_cnt2), sat(e_br, 3));
    chk("mispred_cnt2", 32'(mispred_cnt2), sat(e_mp, 3));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) begin
      model_step(m_lk);
      if (!stall) m_lk = fetch_pc;
    end
    #1;
    compare_all();
  endtask

  task automatic idle();
    stall = 0; fetch_pc = '0; btb_hit = 0;
    btb_pred_pc = '0; ex_is_branch = 0;
    ex_taken = 0; ex_target = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    m_lk = '0;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 0;
  endtask

  logic [31:0] tg[4];

  initial begin
    tg[0] = 32'h100; tg[1] = 32'h200;
    tg[2] = 32'h300; tg[3] = 32'h400;
    idle();
    do_reset();

    // reset: quiet for 5 idle cycles
    repeat (5) begin
      step();
      chk("rst_redirect", 32'(redirect), 32'h0);
      chk("rst_pc", redirect_pc, 32'h0);
      chk("rst_upd", 32'(btb_update), 32'h0);
      chk("rst_bcnt", 32'(branch_cnt), 32'h0);
    end

    // taken branch at 0x80 predicted not-taken
    fetch_pc = 32'h80; step();
    fetch_pc = 32'h0;  step();
    step();
    ex_is_branch = 1; ex_taken = 1;
    ex_target = 32'h200;
    step();
    chk("mp_redirect", 32'(redirect), 32'h1);
    chk("mp_pc", redirect_pc, 32'h200);
    chk("mp_ffd", {flush_f, flush_d}, 32'h3);
    chk("mp_upd", 32'(btb_update), 32'h1);
    chk("mp_bpc", btb_pc, 32'h80);
    chk("mp_bta", btb_bta, 32'h200);
    chk("mp_cnt", 32'(mispred_cnt), 32'h1);
    idle(); step();
    chk("mp_pulse_end", {redirect, btb_update}, 32'h0);

    // BTB hit for lk_pc 0x40
    fetch_pc = 32'h40; step();
    fetch_pc = 32'h44; btb_hit = 1;
    btb_pred_pc = 32'h100;
    step();
    chk("btb_redirect", 32'(redirect), 32'h1);
    chk("btb_pc_out", redirect_pc, 32'h100);
    chk("btb_ffd", {flush_f, flush_d}, 32'h2);
    idle(); step();
    chk("btb_pulse_end", 32'(redirect), 32'h0);

    // predicted taken to 0x300, resolves not-taken
    fetch_pc = 32'h90; step();
    fetch_pc = 32'h0; btb_hit = 1;
    btb_pred_pc = 32'h300;
    step();
    idle(); step();
    ex_is_branch = 1; ex_taken = 0;
    ex_target = 32'h555;
    step();
    chk("nt_redirect", 32'(redirect), 32'h1);
    chk("nt_pc", redirect_pc, 32'h94);
    chk("nt_upd", 32'(btb_update), 32'h0);
    chk("nt_cnt", 32'(mispred_cnt), 32'h2);
    idle(); step();

    // mispredict and BTB hit together
    fetch_pc = 32'hA0; step();
    idle(); step();
    step();
    ex_is_branch = 1; ex_taken = 1;
    ex_target = 32'h400;
    btb_hit = 1; btb_pred_pc = 32'h700;
    step();
    chk("both_pc", redirect_pc, 32'h400);
    chk("both_fd", 32'(flush_d), 32'h1);
    idle(); btb_hit = 1; btb_pred_pc = 32'h700;
    step();
    chk("rec_ignore", {redirect, flush_f}, 32'h0);
    idle(); step();

    // stall across a resolving branch
    fetch_pc = 32'hB0; step();
    idle(); step();
    step();
    stall = 1; ex_is_branch = 1; ex_taken = 1;
    ex_target = 32'h600;
    repeat (2) begin
      step();
      chk("stl_quiet", {redirect, btb_update}, 32'h0);
      chk("stl_bcnt", 32'(branch_cnt), 32'h3);
    end
    stall = 0;
    step();
    chk("stl_redirect", 32'(redirect), 32'h1);
    chk("stl_pc", redirect_pc, 32'h600);
    chk("stl_bpc", btb_pc, 32'hB0);
    chk("stl_bcnt4", 32'(branch_cnt), 32'h4);
    chk("sat2_mp", 32'(mispred_cnt2), 32'h3);
    chk("sat2_br", 32'(branch_cnt2), 32'h3);
    idle(); step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 99) < 15);
      fetch_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      btb_hit = $urandom_range(0, 1) == 1;
      btb_pred_pc = tg[$urandom_range(0, 3)];
      ex_is_branch = $urandom_range(0, 1) == 1;
      ex_taken = $urandom_range(0, 1) == 1;
      ex_target = tg[$urandom_range(0, 3)];
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
